game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game-flow controller between the player inputs, the snake/apple datapath and the VGA renderer. It runs the game state machine (title, run, pause, game over, win) and issues the one-cycle soft reset that restarts the datapath. It schedules snake movement ticks from the VGA frame strobe and holds each tick as a request until the snake acknowledges it. It also tracks score and speed level, shortening the tick period as apples are eaten.

## Interface
- START_FRAMES, 12: frames per tick at level 0; range 2..63.
- MIN_FRAMES, 3: fastest tick period in frames; range 1..START_FRAMES.
- APPLES_PER_LEVEL, 4: apples per speed-up; range 1..15.
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; asynchronous, active-high.
- i_start  in  1  start/restart button; debounced level.
- i_pause  in  1  pause toggle button; debounced level.
- i_frame  in  1  one-cycle pulse per VGA frame.
- i_apple_ready  in  1  apple placement valid; ticks are only issued while high.
- i_tick_ack  in  1  one-cycle pulse from the snake when it consumes a tick.
- i_failure  in  1  snake failure pulse.
- i_success  in  1  snake success pulse.
- i_eat  in  1  apple eaten pulse.
- o_tick  out  1  tick request; held high until acknowledged.
- o_tick_lost  out  1  one-cycle pulse when a tick expires while the previous one is still pending.
- o_game_rst  out  1  one-cycle soft reset for the snake and apple blocks.
- o_state  out  3  state code: IDLE=0, RUN=1, PAUSE=2, OVER=3, WIN=4.
- o_score  out  8  apples eaten; saturates at 255.
- o_level  out  6  current speed level.

## Operation
- Edge detection:
  - i_start and i_pause each have a previous-sample register, reset to 1.
  - An edge is the current sample high while the previous sample is low.
  - A button held through reset therefore does not fire.
- State machine (transitions on clk):
  - IDLE, on start edge: go to RUN; o_game_rst=1 for that one cycle; score, level and apple counter cleared; period=START_FRAMES; frame counter=START_FRAMES.
  - RUN, on i_failure: go to OVER. Otherwise on i_success: go to WIN. Otherwise on pause edge: go to PAUSE. Priority order is failure, success, pause.
  - PAUSE, on pause edge: return to RUN. The frame counter is frozen. Start edges are ignored.
  - OVER or WIN, on start edge: same restart action as from IDLE. Pause edges are ignored.
- Tick scheduling (RUN only):
  - On each i_frame, the frame counter decrements.
  - When the counter value is 1 at an i_frame, it expires: the counter reloads with the current period, and then:
    - if o_tick is already 1 (registered value), o_tick_lost pulses and o_tick stays 1;
    - otherwise, if i_apple_ready=1, o_tick is set to 1;
    - otherwise the tick is skipped silently.
  - i_tick_ack while o_tick=1 clears o_tick on the next edge. i_tick_ack while o_tick=0 is ignored.
  - Leaving RUN clears o_tick; the pending request is discarded.
- Score and level (RUN only):
  - i_eat increments the score, saturating at 255.
  - i_eat also increments a 4-bit apple counter. When the counter equals APPLES_PER_LEVEL-1 at an i_eat, it wraps to 0, and if period > MIN_FRAMES then period decrements and o_level increments.
  - A new period takes effect at the next reload; the running count is not truncated.
  - Outside RUN, i_eat, i_failure and i_success are ignored.

## Timing
- All outputs are registered.
- Reset values: o_state=IDLE, o_tick=0, o_tick_lost=0, o_game_rst=0, o_score=0, o_level=0; period=START_FRAMES; frame counter=START_FRAMES; button previous-sample registers=1.
- o_game_rst is high in the first cycle after the start edge, coincident with o_state becoming RUN.
- o_tick rises in the cycle after the expiring i_frame. It falls in the cycle after i_tick_ack.
- Simultaneous events:
  - Expiry and ack in the same cycle: o_tick_lost pulses and o_tick clears (ack wins the level; no new request).
  - i_failure and i_eat together: the score is counted and the state becomes OVER.
  - i_failure and i_success together: OVER.
- Reset asserted mid-game returns every register to its reset value immediately and asynchronously; no o_game_rst pulse is generated.

## Test plan
- Reset, release, press i_start: o_game_rst=1 for exactly 1 cycle, o_state=1, o_score=0.
- In RUN with i_apple_ready=1 and acks given promptly: o_tick rises on the cycle after every 12th i_frame; each ack clears it one cycle later.
- Withhold i_tick_ack across two expiries: exactly one o_tick_lost pulse; o_tick stays high; after the ack, no tick until the next expiry.
- Eat 4 apples: o_score=4, o_level=1, and the next reload gives 11 frames. Eat 40 apples: o_level stops at 9 (period=3) and o_score=40.
- Pause edge: o_state=2, o_tick clears, and 20 frames produce no tick. Second pause edge: o_state=1, and counting resumes from the frozen value.
- Pulse i_failure and i_success in the same cycle: o_state=3. A start edge then gives o_game_rst=1, o_state=1, o_score=0, o_level=0.

Source files
------------

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: groups every game-flow signal between the sequencer
// and its surroundings (buttons, VGA frame strobe, snake/apple datapath, renderer).
//   master modport: the sequencer (consumes i_*, drives o_*)
//   slave modport : the environment (drives i_*, consumes o_*)
interface game_sequencer_if;
    logic       i_start;        // start/restart button, debounced level
    logic       i_pause;        // pause toggle button, debounced level
    logic       i_frame;        // one-cycle pulse per VGA frame
    logic       i_apple_ready;  // apple placement valid
    logic       i_tick_ack;     // snake consumed the tick
    logic       i_failure;      // snake failure pulse
    logic       i_success;      // snake success pulse
    logic       i_eat;          // apple eaten pulse
    logic       o_tick;         // tick request, held until acknowledged
    logic       o_tick_lost;    // tick expired while previous still pending
    logic       o_game_rst;     // one-cycle soft reset for snake/apple
    logic [2:0] o_state;        // IDLE=0 RUN=1 PAUSE=2 OVER=3 WIN=4
    logic [7:0] o_score;        // apples eaten, saturating
    logic [5:0] o_level;        // speed level

    modport master (
        input  i_start, i_pause, i_frame, i_apple_ready, i_tick_ack,
               i_failure, i_success, i_eat,
        output o_tick, o_tick_lost, o_game_rst, o_state, o_score, o_level
    );

    modport slave (
        output i_start, i_pause, i_frame, i_apple_ready, i_tick_ack,
               i_failure, i_success, i_eat,
        input  o_tick, o_tick_lost, o_game_rst, o_state, o_score, o_level
    );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow controller. Runs the title/run/pause/over/win
// state machine, issues the one-cycle datapath soft reset on (re)start,
// schedules snake movement ticks from the VGA frame strobe and tracks
// score and speed level (each level shortens the tick period by one frame).
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - game_sequencer_if.master (buttons, frame strobe, snake handshake,
//          state/score/level outputs); all outputs are registered.
module game_sequencer #(
    parameter int unsigned START_FRAMES     = 12,
    parameter int unsigned MIN_FRAMES       = 3,
    parameter int unsigned APPLES_PER_LEVEL = 4
) (
    input logic              clk,
    input logic              rst,
    game_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRun   = 3'd1,
        StPause = 3'd2,
        StOver  = 3'd3,
        StWin   = 3'd4
    } state_e;

    localparam logic [5:0] StartCnt = 6'(START_FRAMES);
    localparam logic [5:0] MinCnt   = 6'(MIN_FRAMES);
    localparam logic [3:0] AplLast  = 4'(APPLES_PER_LEVEL - 1);

    state_e     state_q;
    logic       start_prev_q;
    logic       pause_prev_q;
    logic [5:0] frame_cnt_q;
    logic [5:0] period_q;
    logic [3:0] apple_cnt_q;
    logic [7:0] score_q;
    logic [5:0] level_q;
    logic       tick_q;
    logic       tick_lost_q;
    logic       game_rst_q;

    logic start_edge;
    logic pause_edge;
    logic expire;

    // Previous samples reset to 1 so a button held through reset does not fire.
    assign start_edge = bus.i_start & ~start_prev_q;
    assign pause_edge = bus.i_pause & ~pause_prev_q;
    assign expire     = bus.i_frame && (frame_cnt_q == 6'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            start_prev_q <= 1'b1;
            pause_prev_q <= 1'b1;
            frame_cnt_q  <= StartCnt;
            period_q     <= StartCnt;
            apple_cnt_q  <= 4'd0;
            score_q      <= 8'd0;
            level_q      <= 6'd0;
            tick_q       <= 1'b0;
            tick_lost_q  <= 1'b0;
            game_rst_q   <= 1'b0;
        end else begin
            start_prev_q <= bus.i_start;
            pause_prev_q <= bus.i_pause;
            game_rst_q   <= 1'b0;
            tick_lost_q  <= 1'b0;

            unique case (state_q)
                StIdle, StOver, StWin: begin
                    if (start_edge) begin
                        state_q     <= StRun;
                        game_rst_q  <= 1'b1;
                        score_q     <= 8'd0;
                        level_q     <= 6'd0;
                        apple_cnt_q <= 4'd0;
                        period_q    <= StartCnt;
                        frame_cnt_q <= StartCnt;
                        tick_q      <= 1'b0;
                    end
                end

                StRun: begin
                    // Reload uses the registered period, so a speed-up from an
                    // apple eaten this cycle only applies to the following reload.
                    if (bus.i_frame) begin
                        frame_cnt_q <= expire ? period_q : frame_cnt_q - 6'd1;
                    end

                    if (expire && tick_q) begin
                        tick_lost_q <= 1'b1;
                    end

                    // Ack wins the level even when an expiry coincides with it.
                    if (tick_q) begin
                        tick_q <= ~bus.i_tick_ack;
                    end else if (expire && bus.i_apple_ready) begin
                        tick_q <= 1'b1;
                    end

                    if (bus.i_eat) begin
                        if (score_q != 8'hff) begin
                            score_q <= score_q + 8'd1;
                        end
                        if (apple_cnt_q == AplLast) begin
                            apple_cnt_q <= 4'd0;
                            if (period_q > MinCnt) begin
                                period_q <= period_q - 6'd1;
                                level_q  <= level_q + 6'd1;
                            end
                        end else begin
                            apple_cnt_q <= apple_cnt_q + 4'd1;
                        end
                    end

                    // Leaving RUN discards any pending tick request.
                    if (bus.i_failure) begin
                        state_q <= StOver;
                        tick_q  <= 1'b0;
                    end else if (bus.i_success) begin
                        state_q <= StWin;
                        tick_q  <= 1'b0;
                    end else if (pause_edge) begin
                        state_q <= StPause;
                        tick_q  <= 1'b0;
                    end
                end

                StPause: begin
                    if (pause_edge) begin
                        state_q <= StRun;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_tick      = tick_q;
    assign bus.o_tick_lost = tick_lost_q;
    assign bus.o_game_rst  = game_rst_q;
    assign bus.o_state     = state_q;
    assign bus.o_score     = score_q;
    assign bus.o_level     = level_q;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

    localparam int START = 12;
    localparam int MINF  = 3;
    localparam int APL   = 4;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_OVER  = 3;
    localparam int S_WIN   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    game_sequencer_if gif ();

    game_sequencer #(
        .START_FRAMES    (START),
        .MIN_FRAMES      (MINF),
        .APPLES_PER_LEVEL(APL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(gif)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: game state, pending tick, frames left, apples eaten
    // this game (unsaturated); score and level are derived from the apple total.
    int m_state;
    int m_cnt;
    int m_eaten;
    bit m_tick;
    bit m_lost;
    bit m_grst;
    bit m_sprev;
    bit m_pprev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int level_of(input int eaten);
        int l;
        l = eaten / APL;
        return (l > START - MINF) ? START - MINF : l;
    endfunction

    function automatic int score_of(input int eaten);
        return (eaten > 255) ? 255 : eaten;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_cnt   = START;
        m_eaten = 0;
        m_tick  = 0;
        m_lost  = 0;
        m_grst  = 0;
        m_sprev = 1;
        m_pprev = 1;
    endtask

    task automatic model_step(input bit st, input bit ps, input bit fr, input bit ar,
                              input bit ack, input bit fl, input bit sc, input bit et);
        bit st_e;
        bit ps_e;
        bit expired;
        st_e    = st && !m_sprev;
        ps_e    = ps && !m_pprev;
        m_sprev = st;
        m_pprev = ps;
        m_lost  = 0;
        m_grst  = 0;
        expired = 0;
        case (m_state)
            S_RUN: begin
                if (fr) begin
                    if (m_cnt == 1) begin
                        expired = 1;
                        m_cnt   = START - level_of(m_eaten);
                    end else begin
                        m_cnt = m_cnt - 1;
                    end
                end
                if (expired && m_tick) m_lost = 1;
                if (m_tick && ack) m_tick = 0;
                else if (!m_tick && expired && ar) m_tick = 1;
                if (et) m_eaten = m_eaten + 1;
                if (fl) begin
                    m_state = S_OVER;
                    m_tick  = 0;
                end else if (sc) begin
                    m_state = S_WIN;
                    m_tick  = 0;
                end else if (ps_e) begin
                    m_state = S_PAUSE;
                    m_tick  = 0;
                end
            end
            S_PAUSE: if (ps_e) m_state = S_RUN;
            default: begin
                if (st_e) begin
                    m_state = S_RUN;
                    m_grst  = 1;
                    m_eaten = 0;
                    m_cnt   = START;
                    m_tick  = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("tick",      gif.o_tick,      m_tick);
        check("tick_lost", gif.o_tick_lost, m_lost);
        check("game_rst",  gif.o_game_rst,  m_grst);
        check("state",     gif.o_state,     m_state);
        check("score",     gif.o_score,     score_of(m_eaten));
        check("level",     gif.o_level,     level_of(m_eaten));
    endtask

    // Drive one cycle of inputs mid-cycle, advance model on the edge, compare at +1.
    task automatic step(input bit st, input bit ps, input bit fr, input bit ar,
                        input bit ack, input bit fl, input bit sc, input bit et);
        gif.i_start       = st;
        gif.i_pause       = ps;
        gif.i_frame       = fr;
        gif.i_apple_ready = ar;
        gif.i_tick_ack    = ack;
        gif.i_failure     = fl;
        gif.i_success     = sc;
        gif.i_eat         = et;
        @(posedge clk);
        model_step(st, ps, fr, ar, ack, fl, sc, et);
        #1;
        compare_all();
    endtask

    // n frames, one every two cycles; optional prompt ack of any pending tick.
    task automatic run_frames(input int n, input bit prompt, output int rises,
                              output int losts);
        bit prev;
        rises = 0;
        losts = 0;
        prev  = gif.o_tick;
        repeat (n) begin
            for (int k = 0; k < 2; k++) begin
                step(0, 0, (k == 0), 1, prompt && gif.o_tick, 0, 0, 0);
                if (gif.o_tick && !prev) rises++;
                if (gif.o_tick_lost) losts++;
                prev = gif.o_tick;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, gif.o_state,     S_IDLE);
        check({tag, "_tick"},  gif.o_tick,      0);
        check({tag, "_lost"},  gif.o_tick_lost, 0);
        check({tag, "_grst"},  gif.o_game_rst,  0);
        check({tag, "_score"}, gif.o_score,     0);
        check({tag, "_level"}, gif.o_level,     0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int  rises;
        int  losts;
        int  guard;
        bit  st_l;
        bit  ps_l;
        bit  fr;
        bit  ar;
        bit  ack;
        bit  fl;
        bit  sc;
        bit  et;

        gif.i_start       = 0;
        gif.i_pause       = 0;
        gif.i_frame       = 0;
        gif.i_apple_ready = 0;
        gif.i_tick_ack    = 0;
        gif.i_failure     = 0;
        gif.i_success     = 0;
        gif.i_eat         = 0;
        model_reset();
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // Start: one-cycle soft reset coincident with RUN.
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        check("start_grst",  gif.o_game_rst, 1);
        check("start_state", gif.o_state,    S_RUN);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        check("start_grst_once", gif.o_game_rst, 0);

        // Prompt acks: one tick per 12 frames.
        run_frames(36, 1, rises, losts);
        check("prompt_rises", rises, 3);
        check("prompt_losts", losts, 0);

        // Withheld ack across two expiries.
        run_frames(24, 0, rises, losts);
        check("withheld_rises", rises, 1);
        check("withheld_losts", losts, 1);
        check("withheld_tick",  gif.o_tick, 1);
        step(0, 0, 0, 1, 1, 0, 0, 0);
        check("ack_clears", gif.o_tick, 0);
        run_frames(11, 1, rises, losts);
        check("no_tick_before_expiry", rises, 0);
        run_frames(1, 1, rises, losts);
        check("tick_at_expiry", rises, 1);

        // Four apples: level 1, period 11 from the next reload.
        repeat (4) step(0, 0, 0, 1, 0, 0, 0, 1);
        check("eat4_score", gif.o_score, 4);
        check("eat4_level", gif.o_level, 1);
        run_frames(12, 1, rises, losts);
        check("old_period_rises", rises, 1);
        run_frames(10, 1, rises, losts);
        check("new_period_early", rises, 0);
        run_frames(1, 1, rises, losts);
        check("new_period_11", rises, 1);

        repeat (36) step(0, 0, 0, 1, 0, 0, 0, 1);
        check("eat40_score", gif.o_score, 40);
        check("eat40_level", gif.o_level, 9);
        repeat (220) step(0, 0, 0, 1, 0, 0, 0, 1);
        check("score_sat", gif.o_score, 255);
        check("level_cap", gif.o_level, 9);

        // Pause with a pending tick: tick discarded, counter frozen.
        guard = 0;
        while (!gif.o_tick && guard < 20) begin
            run_frames(1, 0, rises, losts);
            guard++;
        end
        check("pending_before_pause", gif.o_tick, 1);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        check("pause_state", gif.o_state, S_PAUSE);
        check("pause_tick",  gif.o_tick,  0);
        run_frames(20, 1, rises, losts);
        check("pause_no_ticks", rises, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        check("pause_ignores_start", gif.o_state, S_PAUSE);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        check("resume_state", gif.o_state, S_RUN);
        run_frames(6, 1, rises, losts);

        // Failure and success together: OVER wins; restart clears score/level.
        step(0, 0, 0, 1, 0, 1, 1, 1);
        check("fail_succ_state", gif.o_state, S_OVER);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        check("over_ignores_pause", gif.o_state, S_OVER);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        check("restart_grst",  gif.o_game_rst, 1);
        check("restart_state", gif.o_state,    S_RUN);
        check("restart_score", gif.o_score,    0);
        check("restart_level", gif.o_level,    0);
        repeat (5) step(1, 0, 0, 1, 0, 0, 0, 1);

        // Mid-game reset with start held through it: no spurious start.
        async_reset();
        repeat (4) step(1, 0, 1, 1, 0, 0, 0, 0);
        check("held_start_no_fire", gif.o_state, S_IDLE);

        // Randomized traffic against the model.
        st_l = 1;
        ps_l = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) st_l = ~st_l;
            if ($urandom_range(0, 39) == 0) ps_l = ~ps_l;
            fr  = ($urandom_range(0, 2) == 0);
            ar  = ($urandom_range(0, 4) != 0);
            ack = gif.o_tick ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            fl  = ($urandom_range(0, 249) == 0);
            sc  = ($urandom_range(0, 399) == 0);
            et  = ($urandom_range(0, 5) == 0);
            step(st_l, ps_l, fr, ar, ack, fl, sc, et);
            if ($urandom_range(0, 799) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
